text_buffer_writer: RTL and testbench

//  Write side of the 15x40 character screen. Accepts a byte stream, places it at a cursor and updates the text RAM.

---
 rtl/text_buffer_writer_pkg.sv | 53 +++++
 rtl/text_buffer_writer_if.sv | 30 +++
 rtl/text_buffer_writer_text_ram.sv | 45 ++++
 rtl/text_buffer_writer.sv | 156 +++++++++++++++
 tb/tb_text_buffer_writer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/text_buffer_writer_pkg.sv
// ============================================================================
// Module : text_buffer_writer_pkg
// Brief  : Screen geometry, control codes and cell addressing for the text buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package text_buffer_writer_pkg;

    localparam int ROW_NUMBER     = 15;
    localparam int COL_NUMBER     = 40;
    localparam int ROW_BIT_LEN    = 4;
    localparam int COL_BIT_LEN    = 6;
    localparam int CHAR_ID_LENGTH = 8;
    localparam int TOTAL_CHAR     = 129;
    localparam int TOTAL_CELLS    = ROW_NUMBER * COL_NUMBER;
    localparam int ADDR_W         = 10;

    typedef logic [ROW_BIT_LEN-1:0]    row_t;
    typedef logic [COL_BIT_LEN-1:0]    col_t;
    typedef logic [CHAR_ID_LENGTH-1:0] char_t;
    typedef logic [ADDR_W-1:0]         addr_t;

    localparam row_t  LAST_ROW    = row_t'(ROW_NUMBER - 1);
    localparam col_t  LAST_COL    = col_t'(COL_NUMBER - 1);
    localparam addr_t LAST_CELL   = addr_t'(TOTAL_CELLS - 1);

    localparam char_t BLANK_ID    = 8'h20;
    localparam char_t FIRST_GLYPH = 8'h20;
    localparam char_t LAST_GLYPH  = char_t'(TOTAL_CHAR - 1);
    localparam char_t CC_LF       = 8'h0A;
    localparam char_t CC_CR       = 8'h0D;
    localparam char_t CC_BS       = 8'h08;
    localparam char_t CC_FF       = 8'h0C;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL  = 2'd0,
        ST_IDLE       = 2'd1,
        ST_CLEAR_LINE = 2'd2
    } state_t;

    function automatic addr_t cell_addr(input row_t row, input col_t col);
        return addr_t'(row) * addr_t'(COL_NUMBER) + addr_t'(col);
    endfunction

    // No scrolling: advancing past the last row wraps to the top.
    function automatic row_t next_row(input row_t row);
        return (row == LAST_ROW) ? '0 : row + row_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/text_buffer_writer_if.sv
// ============================================================================
// Module : text_buffer_writer_if
// Brief  : Byte-stream write handshake plus character read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface text_buffer_writer_if;
    import text_buffer_writer_pkg::*;

    logic  wr_valid;
    logic  wr_ready;
    char_t wr_data;
    row_t  rd_row;
    col_t  rd_col;
    char_t rd_char_id;

    modport master (
        output wr_valid, wr_data, rd_row, rd_col,
        input  wr_ready, rd_char_id
    );

    modport slave (
        input  wr_valid, wr_data, rd_row, rd_col,
        output wr_ready, rd_char_id
    );

endinterface

`default_nettype wire

// File: rtl/text_buffer_writer_text_ram.sv
// ============================================================================
// Module : text_buffer_writer_text_ram
// Brief  : 600x8 simple dual-port text RAM, registered read with old-data semantics.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module text_buffer_writer_text_ram
    import text_buffer_writer_pkg::*;
(
    input  wire   clk,
    input  wire   reset,
    input  wire   we_i,
    input  addr_t waddr_i,
    input  char_t wdata_i,
    input  wire   rvalid_i,
    input  addr_t raddr_i,
    output char_t rdata_o
);

    char_t mem_q [TOTAL_CELLS];
    char_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range requests read as blank so the encoder never sees garbage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= BLANK_ID;
        end else if (rvalid_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= BLANK_ID;
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/text_buffer_writer.sv
// ============================================================================
// Module : text_buffer_writer
// Brief  : Cursor-driven writer for the 15x40 text screen with line/screen clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module text_buffer_writer
    import text_buffer_writer_pkg::*;
(
    input  wire                 clk,
    input  wire                 reset,
    text_buffer_writer_if.slave bus,
    output row_t                cursor_row_o,
    output col_t                cursor_col_o,
    output logic                busy_o
);

    state_t state_q, state_d;
    addr_t  cnt_q,   cnt_d;
    row_t   row_q,   row_d;
    col_t   col_q,   col_d;

    logic   ram_we;
    addr_t  ram_waddr;
    char_t  ram_wdata;
    logic   ready;
    logic   rd_in_range;
    addr_t  rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR_ALL;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        ram_we    = 1'b0;
        ram_waddr = cell_addr(row_q, col_q);
        ram_wdata = bus.wr_data;
        ready     = 1'b0;

        case (state_q)
            ST_CLEAR_ALL: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = BLANK_ID;
                if (cnt_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + addr_t'(1);
                end
            end

            // The cursor already points at the new row when this state starts.
            ST_CLEAR_LINE: begin
                ram_we    = 1'b1;
                ram_waddr = cell_addr(row_q, cnt_q[COL_BIT_LEN-1:0]);
                ram_wdata = BLANK_ID;
                if (cnt_q[COL_BIT_LEN-1:0] == LAST_COL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + addr_t'(1);
                end
            end

            ST_IDLE: begin
                ready = 1'b1;
                if (bus.wr_valid) begin
                    if (bus.wr_data >= FIRST_GLYPH && bus.wr_data <= LAST_GLYPH) begin
                        ram_we = 1'b1;
                        if (col_q != LAST_COL) begin
                            col_d = col_q + col_t'(1);
                        end else begin
                            col_d   = '0;
                            row_d   = next_row(row_q);
                            state_d = ST_CLEAR_LINE;
                            cnt_d   = '0;
                        end
                    end else begin
                        case (bus.wr_data)
                            CC_LF, CC_CR: begin
                                col_d   = '0;
                                row_d   = next_row(row_q);
                                state_d = ST_CLEAR_LINE;
                                cnt_d   = '0;
                            end
                            CC_BS: begin
                                ram_wdata = BLANK_ID;
                                if (col_q != '0) begin
                                    ram_we    = 1'b1;
                                    ram_waddr = cell_addr(row_q, col_q - col_t'(1));
                                    col_d     = col_q - col_t'(1);
                                end else if (row_q != '0) begin
                                    ram_we    = 1'b1;
                                    ram_waddr = cell_addr(row_q - row_t'(1), LAST_COL);
                                    row_d     = row_q - row_t'(1);
                                    col_d     = LAST_COL;
                                end
                            end
                            CC_FF: begin
                                row_d   = '0;
                                col_d   = '0;
                                state_d = ST_CLEAR_ALL;
                                cnt_d   = '0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR_ALL;
                cnt_d   = '0;
            end
        endcase
    end

    assign rd_in_range = (bus.rd_row <= LAST_ROW) && (bus.rd_col <= LAST_COL);
    assign rd_addr     = rd_in_range ? cell_addr(bus.rd_row, bus.rd_col) : '0;

    text_buffer_writer_text_ram u_text_ram (
        .clk      (clk),
        .reset    (reset),
        .we_i     (ram_we && !reset),
        .waddr_i  (ram_waddr),
        .wdata_i  (ram_wdata),
        .rvalid_i (rd_in_range),
        .raddr_i  (rd_addr),
        .rdata_o  (bus.rd_char_id)
    );

    assign bus.wr_ready = ready;
    assign busy_o       = ~ready;
    assign cursor_row_o = row_q;
    assign cursor_col_o = col_q;

endmodule

`default_nettype wire

// File: tb/tb_text_buffer_writer.sv
// ============================================================================
// Module : tb_text_buffer_writer
// Brief  : Self-checking bench with a screen model and read-data scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_text_buffer_writer;
    import text_buffer_writer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    row_t cursor_row;
    col_t cursor_col;
    logic busy;

    text_buffer_writer_if bus ();

    text_buffer_writer dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cursor_row_o (cursor_row),
        .cursor_col_o (cursor_col),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [600];
    int         m_row;
    int         m_col;
    logic [7:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 600; i++) m_mem[i] = 8'h20;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_adv();
        m_row = (m_row == 14) ? 0 : m_row + 1;
        for (int c = 0; c < 40; c++) m_mem[m_row*40 + c] = 8'h20;
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h80) begin
            m_mem[m_row*40 + m_col] = b;
            if (m_col < 39) m_col++;
            else begin
                m_col = 0;
                model_adv();
            end
        end else if (b == 8'h0A || b == 8'h0D) begin
            m_col = 0;
            model_adv();
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_mem[m_row*40 + m_col] = 8'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = 39;
                m_mem[m_row*40 + m_col] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            model_reset();
        end
    endtask

    // Returns the number of cycles spent waiting for wr_ready.
    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (bus.wr_ready !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.wr_ready !== 1'b1) chk("ready_timeout", 32'(bus.wr_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        wait_idle(2000, n);
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        model_accept(b);
    endtask

    task automatic send_wait(input logic [7:0] b);
        int n;
        send(b);
        wait_idle(2000, n);
    endtask

    task automatic rd_check(input int r, input int c, input string tag);
        bus.rd_row = 4'(r);
        bus.rd_col = 6'(c);
        sb_q.push_back((r < 15 && c < 40) ? m_mem[r*40 + c] : 8'h20);
        @(posedge clk); #1;
        chk(tag, 32'(bus.rd_char_id), 32'(sb_q.pop_front()));
    endtask

    task automatic sweep(input string tag);
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 40; c++)
                rd_check(r, c, tag);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_row"}, 32'(cursor_row), 32'(m_row));
        chk({tag, "_col"}, 32'(cursor_col), 32'(m_col));
    endtask

    initial begin
        int n;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_row   = '0;
        bus.rd_col   = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rd", 32'(bus.rd_char_id), 32'h20);
        chk_cursor("rst_cursor");
        reset = 1'b0;
        wait_idle(2000, n);
        chk("init_clear_cycles", 32'(n), 32'd600);
        sweep("init_sweep");
        rd_check(15, 0, "rd_row_oob");
        rd_check(0, 40, "rd_col_oob");

        // Read and write of the same cell in one cycle sees the old value.
        bus.rd_row = 4'd0;
        bus.rd_col = 6'd0;
        sb_q.push_back(m_mem[0]);
        send(8'h41);
        chk("rd_during_wr", 32'(bus.rd_char_id), 32'(sb_q.pop_front()));
        rd_check(0, 0, "rd_after_wr");
        chk_cursor("after_A");

        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h42;
        for (int i = 0; i < 3; i++) begin
            chk("hold_ready", 32'(bus.wr_ready), 32'd1);
            @(posedge clk); #1;
            model_accept(8'h42);
        end
        bus.wr_valid = 1'b0;
        chk_cursor("after_hold");

        for (int i = 0; i < 35; i++) send(8'h30 + 8'(i));
        chk_cursor("before_wrap");
        send(8'h7E);
        wait_idle(2000, n);
        chk("wrap_busy_cycles", 32'(n), 32'd40);
        chk_cursor("after_wrap");
        sweep("wrap_sweep");

        send_wait(8'h08);
        chk_cursor("bs_row_start");
        rd_check(0, 39, "bs_cell");

        send_wait(8'h0A);
        send(8'h58); send(8'h59); send(8'h5A);
        for (int i = 0; i < 13; i++) send_wait(8'h0A);
        chk_cursor("at_row14");
        send(8'h0D);
        wait_idle(2000, n);
        chk("cr_wrap_busy", 32'(n), 32'd40);
        chk_cursor("after_row_wrap");
        sweep("row_wrap_sweep");

        send_wait(8'h08);
        chk_cursor("bs_origin");
        sweep("bs_origin_sweep");

        send(8'h51);
        send(8'h01);
        send(8'h90);
        send(8'h1F);
        chk_cursor("ignored_codes");
        send(8'h80);
        send(8'h7F);
        sweep("ignored_sweep");

        send(8'h0C);
        wait_idle(2000, n);
        chk("ff_busy_cycles", 32'(n), 32'd600);
        chk_cursor("after_ff");
        sweep("ff_sweep");

        send(8'h61); send(8'h62);
        send(8'h0A);
        repeat (19) @(posedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_mid_busy", 32'(busy), 32'd1);
        chk_cursor("rst_mid_cursor");
        reset = 1'b0;
        wait_idle(2000, n);
        chk("rst_mid_clear_cycles", 32'(n), 32'd600);
        sweep("rst_mid_sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
